// File: rtl/quadrature_step_decoder_if.sv
// Pin-side and decoded-side signals of the quadrature step decoder.
// The master drives the raw phases; the slave (decoder) drives the results.
interface quadrature_step_decoder_if;
   logic       a_in;
   logic       b_in;
   logic       step;
   logic       dir;
   logic       err;
   logic [1:0] ab_filt;

   modport master (
      output a_in, b_in,
      input  step, dir, err, ab_filt
   );

   modport slave (
      input  a_in, b_in,
      output step, dir, err, ab_filt
   );
endinterface

// File: rtl/quadrature_step_decoder.sv
// Synchronises and glitch-filters a 2-phase quadrature pair, then decodes
// it x4 into a one-cycle step pulse, a direction level and a double-change flag.
module quadrature_step_decoder #(
   parameter int FILT_LEN = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   quadrature_step_decoder_if.slave      qd
);

   localparam int              CW      = $clog2(FILT_LEN) + 1;
   localparam logic [CW-1:0]   CNT_MAX = CW'(FILT_LEN - 1);

   typedef enum logic [1:0] {WAIT, LOAD, TRACK} state_t;

   state_t     state_q;
   logic       wait_q;
   logic [1:0] prev_q;
   logic       step_q;
   logic       err_q;
   logic       dir_q;

   logic [1:0] pins_w;
   logic [1:0] s2_w;
   logic [1:0] filt_w;

   logic       step_d;
   logic       err_d;
   logic       dir_d;
   logic [1:0] delta_d;

   // Bit 1 is phase A, bit 0 is phase B, matching the {A,B} ordering.
   assign pins_w = {qd.a_in, qd.b_in};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         logic          s1_q;
         logic          s2_q;
         logic          filt_q;
         logic [CW-1:0] cnt_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s1_q   <= 1'b0;
               s2_q   <= 1'b0;
               filt_q <= 1'b0;
               cnt_q  <= '0;
            end else begin
               s1_q <= pins_w[gi];
               s2_q <= s1_q;
               if (state_q == LOAD) begin
                  filt_q <= s2_q;
                  cnt_q  <= '0;
               end else if (state_q == TRACK) begin
                  if (s2_q != filt_q) begin
                     if (cnt_q == CNT_MAX) begin
                        filt_q <= s2_q;
                        cnt_q  <= '0;
                     end else begin
                        cnt_q <= cnt_q + 1'b1;
                     end
                  end else begin
                     cnt_q <= '0;
                  end
               end
            end
         end

         assign s2_w[gi]   = s2_q;
         assign filt_w[gi] = filt_q;
      end
   endgenerate

   // Position along the up sequence 00 -> 10 -> 11 -> 01.
   function automatic logic [1:0] gray_pos(input logic [1:0] ab);
      case (ab)
         2'b00:   gray_pos = 2'd0;
         2'b10:   gray_pos = 2'd1;
         2'b11:   gray_pos = 2'd2;
         default: gray_pos = 2'd3;
      endcase
   endfunction

   // Delta +1 is one step up, -1 (3) one step down, 2 means both bits flipped.
   always_comb begin
      step_d  = 1'b0;
      err_d   = 1'b0;
      dir_d   = dir_q;
      delta_d = gray_pos(filt_w) - gray_pos(prev_q);
      if (state_q == TRACK) begin
         case (delta_d)
            2'd1: begin
               step_d = 1'b1;
               dir_d  = 1'b1;
            end
            2'd3: begin
               step_d = 1'b1;
               dir_d  = 1'b0;
            end
            2'd2:    err_d = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= WAIT;
         wait_q  <= 1'b0;
         prev_q  <= 2'b00;
         step_q  <= 1'b0;
         err_q   <= 1'b0;
         dir_q   <= 1'b1;
      end else begin
         step_q <= step_d;
         err_q  <= err_d;
         dir_q  <= dir_d;
         case (state_q)
            WAIT: begin
               if (wait_q) begin
                  state_q <= LOAD;
               end
               wait_q <= 1'b1;
            end
            LOAD: begin
               // Seed from the pins so a non-zero idle level is not seen as motion.
               prev_q  <= s2_w;
               state_q <= TRACK;
            end
            TRACK: begin
               prev_q <= filt_w;
            end
            default: state_q <= WAIT;
         endcase
      end
   end

   assign qd.step    = step_q;
   assign qd.err     = err_q;
   assign qd.dir     = dir_q;
   assign qd.ab_filt = filt_w;

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Directed bench for quadrature_step_decoder: reset/load, up/down cycles,
// reversal, glitch rejection, double change and mid-count reset (FILT_LEN 4 and 1).
module tb_quadrature_step_decoder;

   logic clk;
   logic rst;

   quadrature_step_decoder_if qd0 ();
   quadrature_step_decoder_if qd1 ();

   quadrature_step_decoder #(.FILT_LEN(4)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .qd  (qd0)
   );

   quadrature_step_decoder #(.FILT_LEN(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .qd  (qd1)
   );

   int checks   = 0;
   int failures = 0;
   int step_cnt = 0;
   int up_cnt   = 0;
   int dn_cnt   = 0;
   int err_cnt  = 0;
   logic [1:0] cur_ab;
   int base_up;
   int base_dn;
   int base_step;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pulse monitor on the falling edge, midway through each registered cycle.
   always @(negedge clk) begin
      if (qd0.step === 1'b1) begin
         step_cnt++;
         if (qd0.dir === 1'b1) up_cnt++;
         else                  dn_cnt++;
      end
      if (qd0.err === 1'b1) err_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One Gray phase held 10 clocks: filter updates on tick 6, step on tick 7.
   task automatic phase(input logic [1:0] ab, input logic exp_dir);
      {qd0.a_in, qd0.b_in} = ab;
      repeat (5) tick();
      chk("filt_hold", 32'(qd0.ab_filt), 32'(cur_ab));
      tick();
      chk("filt_upd", 32'(qd0.ab_filt), 32'(ab));
      chk("step_early", 32'(qd0.step), 32'd0);
      tick();
      chk("step", 32'(qd0.step), 32'd1);
      chk("dir", 32'(qd0.dir), 32'(exp_dir));
      chk("err_on_step", 32'(qd0.err), 32'd0);
      tick();
      chk("step_width", 32'(qd0.step), 32'd0);
      repeat (2) tick();
      cur_ab = ab;
   endtask

   initial begin
      rst = 1'b1;
      qd0.a_in = 1'b1;
      qd0.b_in = 1'b1;
      qd1.a_in = 1'b0;
      qd1.b_in = 1'b0;

      // Pins at 11 through reset: LOAD takes them without a false err.
      repeat (3) tick();
      chk("rst_step", 32'(qd0.step), 32'd0);
      chk("rst_err", 32'(qd0.err), 32'd0);
      chk("rst_dir", 32'(qd0.dir), 32'd1);
      chk("rst_filt", 32'(qd0.ab_filt), 32'd0);
      rst = 1'b0;
      repeat (2) tick();
      chk("wait_filt", 32'(qd0.ab_filt), 32'd0);
      tick();
      chk("load_filt", 32'(qd0.ab_filt), 32'h3);
      tick();
      chk("load_step", 32'(qd0.step), 32'd0);
      chk("load_err", 32'(qd0.err), 32'd0);
      cur_ab = 2'b11;

      // Walk down to 00, full up cycle, full down cycle, then a reversal.
      phase(2'b10, 1'b0);
      phase(2'b00, 1'b0);
      phase(2'b10, 1'b1);
      phase(2'b11, 1'b1);
      phase(2'b01, 1'b1);
      phase(2'b00, 1'b1);
      phase(2'b01, 1'b0);
      phase(2'b11, 1'b0);
      phase(2'b10, 1'b0);
      phase(2'b00, 1'b0);
      phase(2'b10, 1'b1);
      phase(2'b11, 1'b1);
      phase(2'b10, 1'b0);
      phase(2'b00, 1'b0);
      chk("steps_so_far", 32'(step_cnt), 32'd14);
      chk("err_so_far", 32'(err_cnt), 32'd0);

      // A 3-clock glitch must be filtered out entirely.
      base_step = step_cnt;
      qd0.a_in = 1'b1;
      repeat (3) tick();
      qd0.a_in = 1'b0;
      repeat (12) tick();
      chk("glitch_filt", 32'(qd0.ab_filt), 32'd0);
      chk("glitch_steps", 32'(step_cnt - base_step), 32'd0);

      // A 5-clock pulse passes: one step up, then one step down.
      base_up = up_cnt;
      base_dn = dn_cnt;
      qd0.a_in = 1'b1;
      repeat (5) tick();
      qd0.a_in = 1'b0;
      repeat (20) tick();
      chk("pulse_up", 32'(up_cnt - base_up), 32'd1);
      chk("pulse_dn", 32'(dn_cnt - base_dn), 32'd1);
      chk("pulse_filt", 32'(qd0.ab_filt), 32'd0);

      // Both phases flip together: err pulse, no step, dir kept at 0.
      base_step = step_cnt;
      qd0.a_in = 1'b1;
      qd0.b_in = 1'b1;
      repeat (5) tick();
      chk("dbl_filt_hold", 32'(qd0.ab_filt), 32'd0);
      tick();
      chk("dbl_filt", 32'(qd0.ab_filt), 32'h3);
      chk("dbl_err_early", 32'(qd0.err), 32'd0);
      tick();
      chk("dbl_err", 32'(qd0.err), 32'd1);
      chk("dbl_step", 32'(qd0.step), 32'd0);
      chk("dbl_dir", 32'(qd0.dir), 32'd0);
      tick();
      chk("dbl_err_width", 32'(qd0.err), 32'd0);
      chk("dbl_err_cnt", 32'(err_cnt), 32'd1);
      chk("dbl_no_step", 32'(step_cnt - base_step), 32'd0);

      // Reset two counts into an A filter run: immediate reset values, no pulse.
      qd0.a_in = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_step", 32'(qd0.step), 32'd0);
      chk("mid_rst_err", 32'(qd0.err), 32'd0);
      chk("mid_rst_dir", 32'(qd0.dir), 32'd1);
      chk("mid_rst_filt", 32'(qd0.ab_filt), 32'd0);
      repeat (2) tick();
      rst = 1'b0;
      repeat (10) tick();
      chk("post_rst_filt", 32'(qd0.ab_filt), 32'h1);
      chk("post_rst_steps", 32'(step_cnt), 32'd16);
      chk("post_rst_errs", 32'(err_cnt), 32'd1);

      // FILT_LEN=1: filter updates on tick 3, step on tick 4.
      qd1.a_in = 1'b1;
      repeat (2) tick();
      chk("f1_filt_hold", 32'(qd1.ab_filt), 32'd0);
      tick();
      chk("f1_filt", 32'(qd1.ab_filt), 32'h2);
      chk("f1_step_early", 32'(qd1.step), 32'd0);
      tick();
      chk("f1_step", 32'(qd1.step), 32'd1);
      chk("f1_dir", 32'(qd1.dir), 32'd1);
      tick();
      chk("f1_step_width", 32'(qd1.step), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
